// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (3-byte reads) and data
// reads/writes share one single-port synchronous-read 256x8 RAM.
// Data requests normally win; a starvation counter forces a fetch grant
// after STARVE_MAX consecutive fetch losses.
module mem_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic [23:0] if_instr,
    output logic        if_valid,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [7:0]  dm_addr,
    input  logic [7:0]  dm_wdata,
    output logic [7:0]  dm_rdata,
    output logic        dm_valid,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRD, DWR, DONE} state_t;

    state_t        state;
    state_t        nextState;
    logic [SW-1:0] starveCnt;
    logic [1:0]    stepCnt;
    logic [7:0]    addrReg;
    logic [7:0]    wdataReg;
    logic          starveHit;
    logic          grantDm;
    logic          grantIf;
    logic [7:0]    fetchOff;

    // Arbitration: only evaluated in IDLE; dm wins unless fetch has starved.
    always_comb begin
        starveHit = (starveCnt == SW'(STARVE_MAX));
        grantDm   = (state == IDLE) && dm_req && !(if_req && starveHit);
        grantIf   = (state == IDLE) && if_req && !grantDm;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; stepCnt sequences the multi-cycle FETCH and DRD.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (grantDm) begin
                    nextState = dm_we ? DWR : DRD;
                end else if (grantIf) begin
                    nextState = FETCH;
                end
            end
            FETCH:   if (stepCnt == 2'd3) nextState = DONE;
            DRD:     if (stepCnt == 2'd1) nextState = DONE;
            DWR:     nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request latching, read-data capture, valid pulses and starvation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt <= '0;
            stepCnt   <= 2'd0;
            addrReg   <= 8'd0;
            wdataReg  <= 8'd0;
            if_instr  <= 24'd0;
            dm_rdata  <= 8'd0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantDm || grantIf) begin
                        addrReg  <= grantDm ? dm_addr : if_addr;
                        wdataReg <= dm_wdata;
                        stepCnt  <= 2'd0;
                    end
                    if (grantIf) begin
                        starveCnt <= '0;
                    end else if (grantDm && if_req && !starveHit) begin
                        starveCnt <= starveCnt + 1'b1;
                    end
                end
                FETCH: begin
                    stepCnt <= stepCnt + 2'd1;
                    case (stepCnt)
                        2'd1: if_instr[23:16] <= ram_rdata;
                        2'd2: if_instr[15:8]  <= ram_rdata;
                        2'd3: begin
                            if_instr[7:0] <= ram_rdata;
                            if_valid      <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                DRD: begin
                    stepCnt <= stepCnt + 2'd1;
                    if (stepCnt == 2'd1) begin
                        dm_rdata <= ram_rdata;
                        dm_valid <= 1'b1;
                    end
                end
                DWR:     dm_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // RAM drive: fetch walks A, A+1, A+2 (holding A+2), data ops use A.
    always_comb begin
        fetchOff  = stepCnt[1] ? 8'd2 : {6'd0, stepCnt};
        busy      = (state != IDLE);
        ram_we    = (state == DWR);
        ram_wdata = (state == DWR) ? wdataReg : 8'd0;
        case (state)
            FETCH:    ram_addr = addrReg + fetchOff;
            DRD, DWR: ram_addr = addrReg;
            default:  ram_addr = 8'd0;
        endcase
    end

endmodule
